// File: rtl/alu_datapath_seq_if.sv
// Operand/handshake bundle between the control FSM and alu_datapath_seq.
// The master drives sources, selects and Start; the slave returns the registered result and status.
interface alu_datapath_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] se;
    logic [WIDTH-1:0] ze;
    logic [WIDTH-1:0] sl1;
    logic [1:0]       src_a;
    logic [2:0]       src_b;
    logic [3:0]       alu_op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             carry;

    modport master (
        output pc, acc, sp, mdr, se, ze, sl1, src_a, src_b, alu_op, start,
        input  busy, done, alu_out, zero, carry
    );

    modport slave (
        input  pc, acc, sp, mdr, se, ze, sl1, src_a, src_b, alu_op, start,
        output busy, done, alu_out, zero, carry
    );
endinterface

// File: rtl/alu_datapath_seq.sv
// Operand-select ALU with registered result/flags and an iterative shift-add multiplier.
// Single-cycle ops complete on the Start edge; MUL holds Busy for WIDTH cycles.
module alu_datapath_seq #(
    parameter int WIDTH   = 16,
    parameter int PC_STEP = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    alu_datapath_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_zero;
    logic               r_carry;
    logic               r_done;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_last;

    always_comb begin
        w_a = '0;
        case (bus.src_a)
            2'd0:    w_a = bus.pc;
            2'd1:    w_a = bus.acc;
            2'd2:    w_a = bus.sp;
            default: w_a = '0;
        endcase
    end

    always_comb begin
        w_b = '0;
        case (bus.src_b)
            3'd0:    w_b = WIDTH'(PC_STEP);
            3'd1:    w_b = bus.se;
            3'd2:    w_b = bus.mdr;
            3'd3:    w_b = bus.ze;
            3'd4:    w_b = bus.sl1;
            default: w_b = '0;
        endcase
    end

    assign w_shamt = w_b[SHW-1:0];

    // MUL is not resolved here; it goes through the iterative path below.
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        case (bus.alu_op)
            OP_ADD:   {w_cout, w_res} = {1'b0, w_a} + {1'b0, w_b};
            OP_SUB: begin
                w_res  = w_a - w_b;
                w_cout = (w_a >= w_b);
            end
            OP_AND:   w_res = w_a & w_b;
            OP_OR:    w_res = w_a | w_b;
            OP_XOR:   w_res = w_a ^ w_b;
            OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            OP_SLL:   w_res = w_a << w_shamt;
            OP_SRL:   w_res = w_a >> w_shamt;
            OP_SRA:   w_res = $unsigned($signed(w_a) >>> w_shamt);
            OP_PASSB: w_res = w_b;
            default:  w_res = '0;
        endcase
    end

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_last      = (r_cnt == SHW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.alu_op == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, w_a};
                            r_mplier <= w_b;
                            r_prod   <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_out   <= w_res;
                            r_zero  <= (w_res == '0);
                            r_carry <= w_cout;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= w_prod_next[WIDTH-1:0];
                        r_zero  <= (w_prod_next[WIDTH-1:0] == '0);
                        r_carry <= |w_prod_next[2*WIDTH-1:WIDTH];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state == S_MUL);
    assign bus.done    = r_done;
    assign bus.alu_out = r_out;
    assign bus.zero    = r_zero;
    assign bus.carry   = r_carry;
endmodule

// File: tb/tb_alu_datapath_seq.sv
// Directed bench for alu_datapath_seq at WIDTH=16, PC_STEP=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each active edge.
module tb_alu_datapath_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_datapath_seq_if #(.WIDTH(16)) bus ();

    alu_datapath_seq #(.WIDTH(16), .PC_STEP(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch with Start for exactly one edge; returns at the falling edge after it.
    task automatic run_op(input logic [1:0] a, input logic [2:0] b, input logic [3:0] op);
        bus.src_a  = a;
        bus.src_b  = b;
        bus.alu_op = op;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] v, input logic z, input logic c);
        chk({tag, "_out"}, 64'(bus.alu_out), 64'(v));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(z));
        chk({tag, "_carry"}, 64'(bus.carry), 64'(c));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
    endtask

    // Counts busy cycles after a MUL launch; optionally pulses an ADD start mid-flight.
    task automatic wait_mul(input string tag, input bit poke);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            if (poke && n == 5) begin
                bus.alu_op = 4'd0;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'd16);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.pc = 16'h0; bus.acc = 16'h0; bus.sp = 16'h0; bus.mdr = 16'h0;
        bus.se = 16'h0; bus.ze = 16'h0; bus.sl1 = 16'h0;
        bus.src_a = 2'd0; bus.src_b = 3'd0; bus.alu_op = 4'd0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", 64'(bus.alu_out), 64'h0);
        chk("rst_zero", 64'(bus.zero), 64'd1);
        chk("rst_carry", 64'(bus.carry), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // PC + PC_STEP
        bus.pc = 16'h0100;
        run_op(2'd0, 3'd0, 4'd0);
        check_res("add_pc", 16'h0102, 1'b0, 1'b0);
        chk("add_pc_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("add_pc_done_drop", 64'(bus.done), 64'd0);
        chk("add_pc_hold", 64'(bus.alu_out), 64'h0102);

        bus.acc = 16'h0005; bus.mdr = 16'h0005;
        run_op(2'd1, 3'd2, 4'd1);
        check_res("sub_eq", 16'h0000, 1'b1, 1'b1);
        bus.acc = 16'h0003;
        run_op(2'd1, 3'd2, 4'd1);
        check_res("sub_borrow", 16'hFFFE, 1'b0, 1'b0);

        bus.acc = 16'h8000; bus.se = 16'h0003;
        run_op(2'd1, 3'd1, 4'd8);
        check_res("sra", 16'hF000, 1'b0, 1'b0);
        bus.acc = 16'hFFFF; bus.ze = 16'h0001;
        run_op(2'd1, 3'd3, 4'd5);
        check_res("slt_neg", 16'h0001, 1'b0, 1'b0);

        // Shift amount uses only the low 4 bits of B: 0x13 -> 3
        bus.acc = 16'h0001; bus.se = 16'h0013;
        run_op(2'd1, 3'd1, 4'd6);
        check_res("sll_mask", 16'h0008, 1'b0, 1'b0);
        bus.acc = 16'h8000; bus.ze = 16'h000F;
        run_op(2'd1, 3'd3, 4'd7);
        check_res("srl15", 16'h0001, 1'b0, 1'b0);
        bus.sp = 16'h00F0;
        run_op(2'd2, 3'd0, 4'd3);
        check_res("or_sp", 16'h00F2, 1'b0, 1'b0);
        run_op(2'd3, 3'd0, 4'd2);
        check_res("and_zeroA", 16'h0000, 1'b1, 1'b0);
        bus.pc = 16'h1234;
        run_op(2'd0, 3'd0, 4'd12);
        check_res("reserved", 16'h0000, 1'b1, 1'b0);
        run_op(2'd0, 3'd6, 4'd10);
        check_res("passb_zeroB", 16'h0000, 1'b1, 1'b0);

        // MUL with operand change and an ignored mid-flight Start
        bus.acc = 16'h0123; bus.mdr = 16'h0010;
        run_op(2'd1, 3'd2, 4'd9);
        bus.acc = 16'h0000; bus.mdr = 16'h0000;
        chk("mul1_no_early_done", 64'(bus.done), 64'd0);
        wait_mul("mul1", 1'b1);
        check_res("mul1", 16'h1230, 1'b0, 1'b0);
        @(negedge clk);
        chk("mul1_done_drop", 64'(bus.done), 64'd0);
        chk("mul1_poke_ignored", 64'(bus.alu_out), 64'h1230);

        bus.acc = 16'hFFFF; bus.mdr = 16'h0002;
        run_op(2'd1, 3'd2, 4'd9);
        wait_mul("mul2", 1'b0);
        check_res("mul2", 16'hFFFE, 1'b0, 1'b1);
        @(negedge clk);

        // Reset five cycles into a MUL, asserted between clock edges
        bus.acc = 16'h0007; bus.mdr = 16'h0009;
        run_op(2'd1, 3'd2, 4'd9);
        repeat (4) @(negedge clk);
        chk("rmul_busy_before", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rmul_busy", 64'(bus.busy), 64'd0);
        chk("rmul_out", 64'(bus.alu_out), 64'h0);
        chk("rmul_zero", 64'(bus.zero), 64'd1);
        chk("rmul_carry", 64'(bus.carry), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.se = 16'h0009;
        run_op(2'd1, 3'd1, 4'd0);
        check_res("rmul_add", 16'h0010, 1'b0, 1'b0);
        @(negedge clk);
        chk("rmul_idle", 64'(bus.busy), 64'd0);

        // Back-to-back ADD, XOR, PASSB
        bus.acc = 16'hFFFF; bus.se = 16'h0001; bus.mdr = 16'h0F0F; bus.sl1 = 16'h1234;
        bus.src_a = 2'd1; bus.src_b = 3'd1; bus.alu_op = 4'd0; bus.start = 1'b1;
        @(posedge clk); @(negedge clk);
        check_res("b2b_add", 16'h0000, 1'b1, 1'b1);
        bus.src_b = 3'd2; bus.alu_op = 4'd4;
        @(posedge clk); @(negedge clk);
        check_res("b2b_xor", 16'hF0F0, 1'b0, 1'b0);
        bus.src_b = 3'd4; bus.alu_op = 4'd10;
        @(posedge clk); @(negedge clk);
        check_res("b2b_passb", 16'h1234, 1'b0, 1'b0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_done_drop", 64'(bus.done), 64'd0);
        chk("b2b_hold", 64'(bus.alu_out), 64'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_datapath_seq.md
Name: alu_datapath_seq

Overview:
Parametrised successor to the accumulator ALU subsystem. The block selects its A and B operands from the datapath sources (PC, ACC, SP, MDR and the immediate forms). It executes single-cycle ALU ops, plus an iterative shift-add multiply that takes WIDTH cycles. Result, Zero and Carry are registered. A Start/Busy/Done handshake lets the control FSM sequence both single-cycle and multi-cycle operations.

Parameters:
WIDTH, 16, datapath width in bits (4..64).
PC_STEP, 2, constant presented on SrcB select 0 (PC increment in bytes).

Ports:
CLK  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
PC  input  WIDTH  program counter
ACC  input  WIDTH  accumulator
SP  input  WIDTH  stack pointer
MDR  input  WIDTH  memory data register
SE  input  WIDTH  sign-extended immediate
ZE  input  WIDTH  zero-extended immediate
SL1  input  WIDTH  immediate shifted left 1
SrcA  input  2  A select: 0 PC, 1 ACC, 2 SP, 3 zero
SrcB  input  3  B select: 0 PC_STEP, 1 SE, 2 MDR, 3 ZE, 4 SL1, 5-7 zero
ALUOp  input  4  operation code (see Behaviour)
Start  input  1  launch operation; sampled on rising CLK
Busy  output  1  multiply in progress
Done  output  1  one-cycle pulse when a result is written
AluOut  output  WIDTH  registered result
Zero  output  1  AluOut == 0 (registered with AluOut)
Carry  output  1  carry/overflow flag (registered with AluOut)

Behaviour:
- Reset (async, any time): AluOut=0, Zero=1, Carry=0, Busy=0, Done=0. An in-flight multiply is abandoned and its partial product discarded.
- Ops (A, B are the selected operands):
  - 0 ADD: A+B; Carry = carry-out.
  - 1 SUB: A-B; Carry = 1 when A>=B unsigned (no borrow).
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SLT: 1 if A<B signed, else 0.
  - 6 SLL, 7 SRL, 8 SRA: shift A by B[clog2(WIDTH)-1:0].
  - 9 MUL: low WIDTH bits of A*B unsigned; Carry = 1 if any of the high WIDTH product bits is nonzero.
  - 10 PASSB: B.
  - 11-15 reserved: result 0.
  - Carry = 0 for every op except ADD, SUB and MUL.
- Single-cycle ops (any op except MUL):
  - Start=1 with Busy=0 at edge k: AluOut, Zero and Carry update at edge k.
  - Done=1 during the cycle after edge k, then returns to 0. Busy stays 0.
- MUL, FSM IDLE -> MUL -> IDLE:
  - Start=1 with Busy=0 at edge k: A and B are latched, iteration counter = 0, Busy=1 from edge k.
  - Each later edge processes one multiplier bit (LSB first): conditional add of the shifted multiplicand into a 2*WIDTH accumulator.
  - At edge k+WIDTH: AluOut/Zero/Carry update, Busy=0, Done=1 for one cycle.
  - Inputs may change freely after edge k.
- Start while Busy=1: ignored. No queueing, no change to the in-flight operation.
- Start back-to-back on single-cycle ops: one result per cycle, and Done stays high across consecutive results.
- Between results, AluOut, Zero and Carry hold their values.
- All arithmetic is modulo 2^WIDTH. Zero always reflects the registered AluOut.

Test Plan:
1. Reset mid-MUL: assert reset 5 cycles into a MUL -> Busy=0, AluOut=0, Zero=1 immediately (async); a subsequent ADD completes normally.
2. WIDTH=16, SrcA=PC=0x0100, SrcB=0, ADD, Start for 1 cycle -> AluOut=0x0102 after one edge, Done pulses 1 cycle, Carry=0, Zero=0.
3. ACC=0x0005, MDR=0x0005, SUB -> AluOut=0, Zero=1, Carry=1. Then ACC=0x0003, SUB -> AluOut=0xFFFE, Carry=0.
4. ACC=0x8000, SE=0x0003, SRA -> 0xF000. Then SLT with ACC=0xFFFF, ZE=0x0001 -> AluOut=1.
5. ACC=0x0123, MDR=0x0010, MUL -> Busy high for exactly 16 cycles, then AluOut=0x1230, Carry=0, Done pulse. Start pulsed mid-MUL is ignored. ACC=0xFFFF × MDR=0x0002 -> AluOut=0xFFFE, Carry=1.
6. Back-to-back ADD, XOR, PASSB on consecutive cycles -> three results on consecutive edges, Done high 3 cycles.
